// File: rtl/mux8_pkg.sv
// mux8_pkg: shared sizes and slot-state type for the 8-channel byte collector.
// Build option: MUX8_RR_ARB_EN selects round-robin arbitration (fixed priority otherwise).
package mux8_pkg;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 16;

  // Output slot occupancy; FULL is exactly when valid_out is high.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks one requesting channel and returns it one-hot and as an index.
// Build option: MUX8_RR_ARB_EN -> search starts at ptr and wraps; otherwise the
// lowest requesting index wins and no pointer input exists.
module rr_arbiter
  import mux8_pkg::*;
(
  input  logic [NUM_CH-1:0] valid,
`ifdef MUX8_RR_ARB_EN
  input  logic [SEL_W-1:0]  ptr,
`endif
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  assign any = |valid;

  // Scan from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
`ifdef MUX8_RR_ARB_EN
      if (valid[SEL_W'(ptr + SEL_W'(k))]) begin
        idx = SEL_W'(ptr + SEL_W'(k));
      end
`else
      if (valid[k]) begin
        idx = SEL_W'(k);
      end
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_grant
      assign grant[gi] = any && (idx == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/mux8_collector.sv
// mux8_collector: collects bytes from 8 valid/ready channels into a single
// registered output slot with one-byte-per-cycle throughput and a transfer counter.
// Build option: MUX8_RR_ARB_EN -> round-robin grant pointer; default is fixed priority.
module mux8_collector #(
  parameter int NUM_CH = mux8_pkg::NUM_CH,
  parameter int DATA_W = mux8_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*DATA_W-1:0]   Data_in,
  input  logic [NUM_CH-1:0]          valid_in,
  output logic [NUM_CH-1:0]          ready_in,
  output logic [DATA_W-1:0]          Data_out,
  output logic [mux8_pkg::SEL_W-1:0] sel_out,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [mux8_pkg::CNT_W-1:0] xfer_cnt
);

  import mux8_pkg::*;

  slot_state_e              state_q, state_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [NUM_CH-1:0]        arb_grant;
  logic [SEL_W-1:0]         arb_idx;
  logic                     arb_any;
  logic                     slot_free;
  logic                     accept;
  logic                     drain;
  logic [DATA_W-1:0]        ch_data [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = Data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef MUX8_RR_ARB_EN
  logic [SEL_W-1:0]         ptr_q, ptr_d;

  rr_arbiter u_arb (
    .valid (valid_in),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );
`else
  rr_arbiter u_arb (
    .valid (valid_in),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );
`endif

  // The slot can take a byte when empty or when it is being drained this edge.
  assign slot_free = (state_q == EMPTY) || ready_out;
  // Grant is already zero when nothing is valid; reset forces no handshake.
  assign ready_in  = (rst_n && slot_free && arb_any) ? arb_grant : '0;
  assign accept    = |ready_in;
  assign drain     = (state_q == FULL) && ready_out;

  assign valid_out = (state_q == FULL);
  assign Data_out  = data_q;
  assign sel_out   = sel_q;
  assign xfer_cnt  = cnt_q;

  // Next slot state, payload, counter and pointer from the two handshakes.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
`ifdef MUX8_RR_ARB_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (drain) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (accept) begin
      data_d = ch_data[arb_idx];
      sel_d  = arb_idx;
`ifdef MUX8_RR_ARB_EN
      ptr_d  = arb_idx + SEL_W'(1);
`endif
    end
  end

  // State register; a reset drops any held byte without counting it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
`ifdef MUX8_RR_ARB_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
`ifdef MUX8_RR_ARB_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux8_collector.sv
// tb_mux8_collector: randomized and directed checks of mux8_collector against a
// behavioural model of the slot, counter and arbitration rules.
// Build option: MUX8_RR_ARB_EN must match the RTL build.
module tb_mux8_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] Data_in = '0;
  logic [7:0]  valid_in = '0;
  logic [7:0]  ready_in;
  logic [7:0]  Data_out;
  logic [2:0]  sel_out;
  logic        valid_out;
  logic        ready_out = 1'b0;
  logic [15:0] xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_valid = 0;
  logic [7:0]  m_data  = '0;
  logic [2:0]  m_sel   = '0;
  logic [15:0] m_cnt   = '0;
  int          m_ptr   = 0;
  logic [7:0]  last_ready;

  always #5 clk = ~clk;

  mux8_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Data_in   (Data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .Data_out  (Data_out),
    .sel_out   (sel_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .xfer_cnt  (xfer_cnt)
  );

  function automatic logic [63:0] ramp_data();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'hA0 + 8'(i);
    return d;
  endfunction

  // One clock: drive inputs, check ready_in, take the edge, check registered outputs.
  task automatic cycle(input logic rst, input logic [7:0] vin, input logic [63:0] din,
                       input logic rout);
    logic [7:0] exp_rdy;
    int g;
    bit free;
    @(negedge clk);
    rst_n = rst; valid_in = vin; Data_in = din; ready_out = rout;
    #1;
    free = !m_valid || rout;
    g = -1;
    if (rst && free) begin
      for (int k = 0; k < 8; k++) begin
`ifdef MUX8_RR_ARB_EN
        int c = (m_ptr + k) % 8;
`else
        int c = k;
`endif
        if (g < 0 && vin[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? (8'd1 << g) : 8'd0;
    last_ready = ready_in;
    n_checks++;
    if (ready_in !== exp_rdy) begin
      n_fail++;
      $display("FAIL ready_in: got %h expected %h (t=%0t)", ready_in, exp_rdy, $time);
    end
    @(posedge clk);
    if (!rst) begin
      m_valid = 0; m_data = '0; m_sel = '0; m_cnt = '0; m_ptr = 0;
    end else begin
      if (m_valid && rout) m_cnt = m_cnt + 16'd1;
      if (g >= 0) begin
        m_valid = 1; m_data = din[g*8 +: 8]; m_sel = 3'(g); m_ptr = (g + 1) % 8;
      end else if (m_valid && rout) begin
        m_valid = 0;
      end
    end
    #1;
    n_checks++;
    if (valid_out !== m_valid) begin
      n_fail++;
      $display("FAIL valid_out: got %b expected %b (t=%0t)", valid_out, m_valid, $time);
    end
    n_checks++;
    if (Data_out !== m_data || sel_out !== m_sel) begin
      n_fail++;
      $display("FAIL data_sel: got %h/%0d expected %h/%0d (t=%0t)",
               Data_out, sel_out, m_data, m_sel, $time);
    end
    n_checks++;
    if (xfer_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL xfer_cnt: got %h expected %h (t=%0t)", xfer_cnt, m_cnt, $time);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'hFF, ramp_data(), 1'b1);
    n_checks++;
    if (valid_out !== 1'b0 || Data_out !== 8'h00 || sel_out !== 3'd0 || xfer_cnt !== 16'h0
        || last_ready !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h s=%0d c=%h r=%h expected all zero",
               valid_out, Data_out, sel_out, xfer_cnt, last_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_idle();
    cycle(1'b0, 8'h00, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'h00, 64'(i) * 64'h0101_0101_0101_0101, 1'b1);
      n_checks++;
      if (last_ready !== 8'h00 || valid_out !== 1'b0 || xfer_cnt !== 16'h0) begin
        n_fail++;
        $display("FAIL idle: got r=%h v=%b c=%h expected 00/0/0000", last_ready, valid_out, xfer_cnt);
      end
    end
    $display("test_idle done");
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_s;
    cycle(1'b0, 8'h00, '0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      cycle(1'b1, 8'hFF, ramp_data(), 1'b1);
`ifdef MUX8_RR_ARB_EN
      exp_s = 3'(k % 8);
`else
      exp_s = 3'd0;
`endif
      n_checks++;
      if (sel_out !== exp_s || Data_out !== (8'hA0 + 8'(exp_s)) || valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_seq[%0d]: got s=%0d d=%h v=%b expected s=%0d d=%h v=1",
                 k, sel_out, Data_out, valid_out, exp_s, 8'hA0 + 8'(exp_s));
      end
    end
    n_checks++;
    if (xfer_cnt !== 16'd8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 8", xfer_cnt);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall();
    logic [63:0] d;
    d = '0;
    d[5*8 +: 8] = 8'h3C;
    cycle(1'b0, 8'h00, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 8'h20, d, 1'b0);
      n_checks++;
      if (Data_out !== 8'h3C || sel_out !== 3'd5 || valid_out !== 1'b1
          || (k > 0 && last_ready !== 8'h00)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got d=%h s=%0d v=%b r=%h expected 3c/5/1/00",
                 k, Data_out, sel_out, valid_out, last_ready);
      end
    end
    cycle(1'b1, 8'h00, d, 1'b1);
    n_checks++;
    if (xfer_cnt !== 16'd1 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got c=%0d v=%b expected 1/0", xfer_cnt, valid_out);
    end
    $display("test_stall done");
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 8'hFF, ramp_data(), 1'b0);
    cycle(1'b1, 8'hFF, ramp_data(), 1'b0);
    cycle(1'b0, 8'hFF, ramp_data(), 1'b0);
    n_checks++;
    if (valid_out !== 1'b0 || Data_out !== 8'h00 || xfer_cnt !== 16'h0 || last_ready !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b d=%h c=%h r=%h expected 0/00/0000/00",
               valid_out, Data_out, xfer_cnt, last_ready);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [7:0]  vin;
    logic [63:0] din;
    for (int i = 0; i < 400; i++) begin
      vin = 8'($urandom) & 8'($urandom);
      din = {$urandom, $urandom};
      cycle(($urandom_range(0, 39) != 0), vin, din, ($urandom_range(0, 3) != 0));
    end
    $display("test_random done");
  endtask

  task automatic test_wrap();
    cycle(1'b0, 8'h00, '0, 1'b1);
    for (int i = 0; i < 65537; i++) begin
      cycle(1'b1, 8'hFF, ramp_data(), 1'b1);
      if (i == 65535) begin
        n_checks++;
        if (xfer_cnt !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL wrap_pre: got %h expected ffff", xfer_cnt);
        end
      end
    end
    n_checks++;
    if (xfer_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap: got %h expected 0000", xfer_cnt);
    end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
